// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/link results in one cycle and waits for load data
// before aligning it. Defining WRITEBACK_RETIRE_CNT_EN enables the 64-bit retire counter.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_pc_plus4,
    input  logic [2:0]        in_ld_funct3,
    input  logic [1:0]        in_ld_lsb,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_w,
    output logic [DATA_W-1:0] rf_data_w,
    output logic              retire,
    output logic [63:0]       retire_cnt
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ldRd_q, ldRd_d;
    logic              ldWe_q, ldWe_d;
    logic [2:0]        ldFunct3_q, ldFunct3_d;
    logic [1:0]        ldLsb_q, ldLsb_d;
    logic              rfWe_q, rfWe_d;
    logic [ADDR_W-1:0] rfAddr_q, rfAddr_d;
    logic [DATA_W-1:0] rfData_q, rfData_d;
    logic              retire_q, retire_d;
    logic              accept;

    // Picks the addressed byte/halfword out of the memory word and extends it.
    function automatic logic [DATA_W-1:0] alignLoad(input logic [DATA_W-1:0] word,
                                                    input logic [2:0]        funct3,
                                                    input logic [1:0]        lsb);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        byteVal = word[{lsb, 3'b000} +: 8];
        halfVal = word[{lsb[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  return {{(DATA_W-8){byteVal[7]}}, byteVal};
            3'b001:  return {{(DATA_W-16){halfVal[15]}}, halfVal};
            3'b100:  return {{(DATA_W-8){1'b0}}, byteVal};
            3'b101:  return {{(DATA_W-16){1'b0}}, halfVal};
            default: return word;
        endcase
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        ldRd_d     = ldRd_q;
        ldWe_d     = ldWe_q;
        ldFunct3_d = ldFunct3_q;
        ldLsb_d    = ldLsb_q;
        rfWe_d     = 1'b0;
        rfAddr_d   = rfAddr_q;
        rfData_d   = rfData_q;
        retire_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_wb_sel == 2'b01) begin
                        state_d    = WAIT_LOAD;
                        ldRd_d     = in_rd;
                        ldWe_d     = in_rd_we;
                        ldFunct3_d = in_ld_funct3;
                        ldLsb_d    = in_ld_lsb;
                    end else begin
                        retire_d = 1'b1;
                        if (in_rd_we && (in_rd != '0) && (in_wb_sel != 2'b11)) begin
                            rfWe_d   = 1'b1;
                            rfAddr_d = in_rd;
                            rfData_d = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_res;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    state_d  = IDLE;
                    retire_d = 1'b1;
                    if (ldWe_q && (ldRd_q != '0)) begin
                        rfWe_d   = 1'b1;
                        rfAddr_d = ldRd_q;
                        rfData_d = alignLoad(dmem_rdata, ldFunct3_q, ldLsb_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ldRd_q     <= '0;
            ldWe_q     <= 1'b0;
            ldFunct3_q <= '0;
            ldLsb_q    <= '0;
            rfWe_q     <= 1'b0;
            rfAddr_q   <= '0;
            rfData_q   <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ldRd_q     <= ldRd_d;
            ldWe_q     <= ldWe_d;
            ldFunct3_q <= ldFunct3_d;
            ldLsb_q    <= ldLsb_d;
            rfWe_q     <= rfWe_d;
            rfAddr_q   <= rfAddr_d;
            rfData_q   <= rfData_d;
            retire_q   <= retire_d;
        end
    end

    assign rf_we     = rfWe_q;
    assign rf_addr_w = rfAddr_q;
    assign rf_data_w = rfData_q;
    assign retire    = retire_q;

`ifdef WRITEBACK_RETIRE_CNT_EN
    // Counts a pulse once it has completed, so the count steps the cycle after retire.
    logic [63:0] retireCnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retireCnt_q <= '0;
        end else if (retire_q) begin
            retireCnt_q <= retireCnt_q + 64'd1;
        end
    end

    assign retire_cnt = retireCnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_writeback_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic          in_rd_we;
    logic [1:0]    in_wb_sel;
    logic [DW-1:0] in_alu_res;
    logic [DW-1:0] in_pc_plus4;
    logic [2:0]    in_ld_funct3;
    logic [1:0]    in_ld_lsb;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_addr_w;
    logic [DW-1:0] rf_data_w;
    logic          retire;
    logic [63:0]   retire_cnt;

    int checks   = 0;
    int failures = 0;

    // Model: a pending load record plus the expected registered outputs.
    bit              mPending;
    logic [AW-1:0]   mRd;
    bit              mWe;
    int              mF3;
    int              mLsb;
    bit              expWe;
    bit              expRetire;
    logic [AW-1:0]   expAddr;
    logic [DW-1:0]   expData;
    longint unsigned mRetires;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_rd_we    (in_rd_we),
        .in_wb_sel   (in_wb_sel),
        .in_alu_res  (in_alu_res),
        .in_pc_plus4 (in_pc_plus4),
        .in_ld_funct3(in_ld_funct3),
        .in_ld_lsb   (in_ld_lsb),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .rf_we       (rf_we),
        .rf_addr_w   (rf_addr_w),
        .rf_data_w   (rf_data_w),
        .retire      (retire),
        .retire_cnt  (retire_cnt)
    );

    function automatic logic [31:0] alignModel(input logic [31:0] w, input int f3, input int lsb);
        int unsigned v;
        int unsigned word;
        word = w;
        case (f3)
            0: begin v = (word >> (8 * lsb)) & 32'd255;  if (v >= 128)   v = v - 256;   end
            4: begin v = (word >> (8 * lsb)) & 32'd255; end
            1: begin v = (word >> (16 * (lsb / 2))) & 32'd65535; if (v >= 32768) v = v - 65536; end
            5: begin v = (word >> (16 * (lsb / 2))) & 32'd65535; end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkOutput();
        logic [63:0] expCnt;
`ifdef WRITEBACK_RETIRE_CNT_EN
        expCnt = mRetires;
`else
        expCnt = 64'd0;
`endif
        checkVal("in_ready",   in_ready,   !mPending);
        checkVal("rf_we",      rf_we,      expWe);
        checkVal("retire",     retire,     expRetire);
        checkVal("rf_addr_w",  rf_addr_w,  expAddr);
        checkVal("rf_data_w",  rf_data_w,  expData);
        checkVal("retire_cnt", retire_cnt, expCnt);
    endtask

    // Predicts the outputs visible after the coming rising edge from the current inputs.
    task automatic modelStep();
        if (!rst_n) begin
            mPending  = 0;
            expWe     = 0;
            expRetire = 0;
            expAddr   = '0;
            expData   = '0;
            mRetires  = 0;
            return;
        end
        if (expRetire) mRetires++;
        expWe     = 0;
        expRetire = 0;
        if (mPending) begin
            if (dmem_rvalid) begin
                mPending  = 0;
                expRetire = 1;
                if (mWe && mRd != 0) begin
                    expWe   = 1;
                    expAddr = mRd;
                    expData = alignModel(dmem_rdata, mF3, mLsb);
                end
            end
        end else if (in_valid) begin
            if (in_wb_sel == 2'd1) begin
                mPending = 1;
                mRd      = in_rd;
                mWe      = in_rd_we;
                mF3      = int'(in_ld_funct3);
                mLsb     = int'(in_ld_lsb);
            end else begin
                expRetire = 1;
                if (in_rd_we && in_rd != 0 && in_wb_sel != 2'd3) begin
                    expWe   = 1;
                    expAddr = in_rd;
                    expData = (in_wb_sel == 2'd2) ? in_pc_plus4 : in_alu_res;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic valid, input logic [AW-1:0] rd,
                                 input logic rdWe, input logic [1:0] sel, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] pc4, input logic [2:0] f3, input logic [1:0] lsb,
                                 input logic rvalid, input logic [DW-1:0] rdata);
        rst_n        = rstn;
        in_valid     = valid;
        in_rd        = rd;
        in_rd_we     = rdWe;
        in_wb_sel    = sel;
        in_alu_res   = alu;
        in_pc_plus4  = pc4;
        in_ld_funct3 = f3;
        in_ld_lsb    = lsb;
        dmem_rvalid  = rvalid;
        dmem_rdata   = rdata;
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        expRetire = 0;
        mRetires  = 0;
        mPending  = 0;

        checkVal("model_lb_lsb3", alignModel(32'h80FF_FFFF, 0, 3), 32'hFFFF_FF80);
        checkVal("model_lhu_lsb2", alignModel(32'hBEEF_1234, 5, 2), 32'h0000_BEEF);
        checkVal("model_lh_lsb1", alignModel(32'h0000_8001, 1, 1), 32'hFFFF_8001);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        checkVal("reset_rf_we", rf_we, 0);
        checkVal("reset_ready", in_ready, 1);
        checkVal("reset_cnt", retire_cnt, 0);

        // ALU back-to-back.
        applyStimulus(1, 1, 5, 1, 2'b00, 32'h11, 32'h100, 0, 0, 0, 0);
        step();
        checkVal("b2b_we0", rf_we, 1);
        checkVal("b2b_addr0", rf_addr_w, 5);
        checkVal("b2b_data0", rf_data_w, 32'h11);
        applyStimulus(1, 1, 6, 1, 2'b00, 32'h22, 32'h104, 0, 0, 0, 0);
        step();
        checkVal("b2b_we1", rf_we, 1);
        checkVal("b2b_addr1", rf_addr_w, 6);
        checkVal("b2b_data1", rf_data_w, 32'h22);
        idle();
        step();
        checkVal("b2b_hold_we", rf_we, 0);
        checkVal("b2b_hold_data", rf_data_w, 32'h22);

        // LB with three wait cycles.
        applyStimulus(1, 1, 7, 1, 2'b01, 32'hDEAD, 0, 3'b000, 2'd3, 0, 0);
        step();
        checkVal("lb_wait_ready1", in_ready, 0);
        applyStimulus(1, 1, 9, 1, 2'b00, 32'h55, 0, 0, 0, 0, 0);
        step();
        checkVal("lb_wait_ready2", in_ready, 0);
        checkVal("lb_wait_nowe", rf_we, 0);
        idle();
        step();
        checkVal("lb_wait_ready3", in_ready, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_FFFF);
        step();
        checkVal("lb_we", rf_we, 1);
        checkVal("lb_addr", rf_addr_w, 7);
        checkVal("lb_data", rf_data_w, 32'hFFFF_FF80);
        checkVal("lb_ready", in_ready, 1);

        // LHU from the upper halfword.
        applyStimulus(1, 1, 8, 1, 2'b01, 0, 0, 3'b101, 2'd2, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF_1234);
        step();
        checkVal("lhu_addr", rf_addr_w, 8);
        checkVal("lhu_data", rf_data_w, 32'h0000_BEEF);

        // Reset while a load is pending.
        applyStimulus(1, 1, 9, 1, 2'b01, 0, 0, 3'b010, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        checkVal("rst_load_ready", in_ready, 1);
        checkVal("rst_load_cnt", retire_cnt, 0);

        // JAL to x0 accepted in the first cycle out of reset, with stale rvalid ignored.
        applyStimulus(1, 1, 0, 1, 2'b10, 0, 32'h400, 0, 0, 1, 32'h1234_5678);
        step();
        checkVal("jal_x0_we", rf_we, 0);
        checkVal("jal_x0_retire", retire, 1);
        checkVal("jal_x0_data", rf_data_w, 0);
        idle();
        step();
`ifdef WRITEBACK_RETIRE_CNT_EN
        checkVal("jal_x0_cnt", retire_cnt, 1);
`else
        checkVal("jal_x0_cnt", retire_cnt, 0);
`endif

        // Randomized traffic, including stray rvalid and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 149) != 0),
                          ($urandom_range(0, 3) != 0),
                          AW'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)),
                          $urandom(), $urandom(),
                          3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0),
                          $urandom());
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register-file data width.
REQ-002 Parameter ADDR_W, default 5, register-file address width.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  upstream (memory stage) instruction valid.
REQ-006 in_ready  out  1  stage can accept an instruction this cycle.
REQ-007 in_rd  in  ADDR_W  destination register index.
REQ-008 in_rd_we  in  1  instruction writes a destination register.
REQ-009 in_wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 none.
REQ-010 in_alu_res  in  DATA_W  ALU result.
REQ-011 in_pc_plus4  in  DATA_W  link value.
REQ-012 in_ld_funct3  in  3  load type (RV32I funct3).
REQ-013 in_ld_lsb  in  2  low two bits of the load address.
REQ-014 dmem_rvalid  in  1  data-memory read data valid.
REQ-015 dmem_rdata  in  DATA_W  data-memory read word.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_addr_w  out  ADDR_W  register-file write address.
REQ-018 rf_data_w  out  DATA_W  register-file write data.
REQ-019 retire  out  1  one-cycle pulse per completed instruction.
REQ-020 retire_cnt  out  64  retired-instruction count.

Function
REQ-021 The FSM SHALL have states IDLE and WAIT_LOAD; in_ready = 1 only in IDLE.
REQ-022 Acceptance SHALL occur when in_valid && in_ready; all in_* fields are captured on acceptance.
REQ-023 For a non-load accept (wb_sel != 01), rf_we/rf_addr_w/rf_data_w/retire SHALL be asserted in the next cycle for exactly one cycle; the FSM stays in IDLE (throughput 1 per cycle).
REQ-024 For a load accept, the FSM SHALL go to WAIT_LOAD; dmem_rvalid is ignored in IDLE.
REQ-025 In WAIT_LOAD, dmem_rvalid = 1 SHALL return the FSM to IDLE, with the aligned load result written in the following cycle; the stage waits indefinitely without rvalid.
REQ-026 Load alignment: LB/LBU select byte lsb[1:0]; LH/LHU select halfword lsb[1] (lsb[0] ignored); LW takes the full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 funct3 011, 110 and 111 SHALL be treated as LW.
REQ-028 rf_we SHALL be 0 when in_rd_we = 0, in_rd = 0 or wb_sel = 11; retire still pulses.
REQ-029 rf_addr_w and rf_data_w SHALL hold their last values when rf_we = 0.

Reset
REQ-030 With rst_n = 0 at a clock edge: FSM = IDLE, rf_we = 0, rf_addr_w = 0, rf_data_w = 0, retire = 0, retire_cnt = 0.
REQ-031 A reset during WAIT_LOAD SHALL discard the pending load, with no write and no retire.
REQ-032 The first acceptance SHALL be possible in the first cycle after rst_n returns to 1.

Configuration
REQ-033 Macro WRITEBACK_RETIRE_CNT_EN defined: retire_cnt SHALL increment by 1 on each retire pulse, wrapping from 2^64-1 to 0.
REQ-034 Macro not defined: retire_cnt SHALL be constant 0 with no counter logic; all other behaviour is unchanged.

Verification
REQ-035 ALU back-to-back: accept rd=5 alu=0x11, then rd=6 alu=0x22 on consecutive cycles -> rf_we on two consecutive cycles writing x5=0x11, x6=0x22.
REQ-036 Load with latency: LB, lsb=3, rd=7; rvalid 3 cycles later with rdata=0x80FF_FFFF -> in_ready low for 3 cycles, then x7=0xFFFF_FF80.
REQ-037 Unsigned half: LHU, lsb=2, rdata=0xBEEF_1234, rd=8 -> x8=0x0000_BEEF.
REQ-038 x0 suppression: JAL with rd=0, wb_sel=10 -> rf_we stays 0, retire pulses, retire_cnt +1 (macro defined).
REQ-039 Reset mid-load: rst_n=0 in WAIT_LOAD, rvalid arrives after reset -> no rf_we, in_ready=1, retire_cnt=0.
REQ-040 Build without WRITEBACK_RETIRE_CNT_EN, 10 instructions retired -> retire_cnt=0 throughout.
